// File: rtl/ce_div_bank.sv
// ce_div_bank: bank of NCH programmable clock-enable dividers with normal/turbo speed pairs.
// Optional macro CE_DIV_NEG_EN builds the mid-period negative-phase strobe (ce_n); otherwise ce_n is 0.
module ce_div_bank #(
  parameter int NCH = 4,
  parameter int DW  = 6
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              en,
  input  logic              align,
  input  logic [NCH*DW-1:0] div_norm,
  input  logic [NCH*DW-1:0] div_fast,
  input  logic [NCH-1:0]    speed_req,
  input  logic [NCH-1:0]    hold,
  output logic [NCH-1:0]    ce_p,
  output logic [NCH-1:0]    ce_n,
  output logic [NCH-1:0]    speed_cur
);

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      logic [DW-1:0] cnt_reg;
      logic [DW-1:0] cnt_next;
      logic          mode_reg;
      logic          mode_next;
      logic          ce_p_reg;
      logic          ce_p_next;
      logic [DW-1:0] div_act;
      logic          wrap;

      assign div_act = mode_reg ? div_fast[gi*DW +: DW] : div_norm[gi*DW +: DW];
      // ">=" lets the counter recover at once when the divisor shrinks below it mid-period.
      assign wrap    = (cnt_reg >= div_act);

      always_comb begin
        cnt_next  = cnt_reg;
        mode_next = mode_reg;
        ce_p_next = 1'b0;
        if (align) begin
          cnt_next = '0;
        end else if (en) begin
          cnt_next  = wrap ? '0 : cnt_reg + DW'(1);
          ce_p_next = wrap;
          // Speed only changes at a period boundary and never while a bus cycle holds it.
          if (wrap && !hold[gi] && (speed_req[gi] != mode_reg))
            mode_next = speed_req[gi];
        end
      end

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
          cnt_reg  <= '0;
          mode_reg <= 1'b0;
          ce_p_reg <= 1'b0;
        end else begin
          cnt_reg  <= cnt_next;
          mode_reg <= mode_next;
          ce_p_reg <= ce_p_next;
        end
      end

      assign ce_p[gi]      = ce_p_reg;
      assign speed_cur[gi] = mode_reg;

`ifdef CE_DIV_NEG_EN
      logic [DW:0] cnt_inc;
      logic [DW:0] half;
      logic        ce_n_reg;
      logic        ce_n_next;

      assign cnt_inc = {1'b0, cnt_reg} + (DW+1)'(1);
      assign half    = ({1'b0, div_act} + (DW+1)'(1)) >> 1;

      always_comb begin
        ce_n_next = 1'b0;
        if (!align && en)
          ce_n_next = (div_act != '0) && !wrap && (cnt_inc == half);
      end

      always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) ce_n_reg <= 1'b0;
        else          ce_n_reg <= ce_n_next;
      end

      assign ce_n[gi] = ce_n_reg;
`else
      assign ce_n[gi] = 1'b0;
`endif
    end
  endgenerate

endmodule
